// File: rtl/imm_decode_queue.sv
// IF/ID buffer: decodes the RISC-V immediate of each accepted instruction at push time
// and queues {inst, pc, imm, fmt} in a DEPTH-entry circular FIFO with flush.
module imm_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_imm,
  output logic [2:0]             out_fmt,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ILL   = 3'd7;

  // Every immediate fits in 32 signed bits; it is assembled there and then
  // sign-extended once to XLEN. Zero-extended fields keep bit 31 clear.
  function automatic logic [XLEN+2:0] decode(input logic [31:0] i);
    logic signed [31:0]     v;
    logic signed [XLEN-1:0] imm;
    logic [2:0]             f;
    logic [2:0]             f3;
    v  = '0;
    f  = FMT_ILL;
    f3 = i[14:12];
    case (i[6:0])
      7'b0110011: f = FMT_R;
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          f = FMT_SHAMT;
          v = {26'b0, (XLEN == 64) ? i[25] : 1'b0, i[24:20]};
        end else begin
          f = FMT_I;
          v = {{20{i[31]}}, i[31:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        f = FMT_I;
        v = {{20{i[31]}}, i[31:20]};
      end
      7'b1110011: begin
        f = FMT_I;
        v = {20'b0, i[31:20]};
      end
      7'b0100011: begin
        f = FMT_S;
        v = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'b1100011: begin
        f = FMT_B;
        v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        f = FMT_U;
        v = {i[31:12], 12'b0};
      end
      7'b1101111: begin
        f = FMT_J;
        v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      default: begin
        f = FMT_ILL;
        v = '0;
      end
    endcase
    imm = XLEN'(v);
    return {f, imm};
  endfunction

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          push, pop;

  // Stage p0: immediate decode of the offered instruction
  logic [XLEN+2:0]        dec_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [2:0]             fmt_p0;
  logic                   vld_p0;

  assign dec_p0 = decode(in_inst);
  assign fmt_p0 = dec_p0[XLEN+2:XLEN];
  assign imm_p0 = dec_p0[XLEN-1:0];

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign vld_p0    = push;
  assign count     = count_q;

  // Stage p1: entry storage, written only on an accepted push
  logic [31:0]            mem_inst [DEPTH];
  logic [XLEN-1:0]        mem_pc   [DEPTH];
  logic signed [XLEN-1:0] mem_imm  [DEPTH];
  logic [2:0]             mem_fmt  [DEPTH];

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      mem_inst[wr_ptr] <= in_inst;
      mem_pc[wr_ptr]   <= in_pc;
      mem_imm[wr_ptr]  <= imm_p0;
      mem_fmt[wr_ptr]  <= fmt_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Stage p2: head presentation, zeroed while empty
  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    out_imm  = '0;
    out_fmt  = '0;
    if (out_valid) begin
      out_inst = mem_inst[rd_ptr];
      out_pc   = mem_pc[rd_ptr];
      out_imm  = mem_imm[rd_ptr];
      out_fmt  = mem_fmt[rd_ptr];
    end
  end

endmodule

// File: tb/tb_imm_decode_queue.sv
// Scoreboard bench for imm_decode_queue: XLEN=32 and XLEN=64 instances share one
// handshake stream; expectations come from an arithmetic immediate model.
module tb_imm_decode_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [31:0] in_pc32;
  assign in_pc32 = in_pc[31:0];

  logic          a_in_ready, a_out_valid;
  logic [31:0]   a_out_inst, a_out_pc, a_out_imm;
  logic [2:0]    a_out_fmt;
  logic [CW-1:0] a_count;
  logic          b_in_ready, b_out_valid;
  logic [31:0]   b_out_inst;
  logic [63:0]   b_out_pc, b_out_imm;
  logic [2:0]    b_out_fmt;
  logic [CW-1:0] b_count;

  imm_decode_queue #(.XLEN(32), .DEPTH(DEPTH)) d32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc32), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_inst(a_out_inst), .out_pc(a_out_pc), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .count(a_count)
  );

  imm_decode_queue #(.XLEN(64), .DEPTH(DEPTH)) d64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_inst(b_out_inst), .out_pc(b_out_pc), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .count(b_count)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
  } exp_t;

  exp_t exp_q[$];
  int   occ;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Immediate value from the instruction-set definition, as plain arithmetic.
  function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt);
    int     si;
    int     t;
    longint r;
    si  = i;
    r   = 0;
    fmt = 3'd7;
    case (i[6:0])
      7'h33: fmt = 3'd0;
      7'h13: begin
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
          fmt = 3'd6;
          r = (xlen == 64) ? ((i >> 20) & 32'd63) : ((i >> 20) & 32'd31);
        end else begin
          fmt = 3'd1;
          r = si >>> 20;
        end
      end
      7'h03, 7'h67: begin fmt = 3'd1; r = si >>> 20; end
      7'h73: begin fmt = 3'd1; r = i >> 20; end
      7'h23: begin fmt = 3'd2; r = longint'(si >>> 25) * 32 + i[11:7]; end
      7'h63: begin
        fmt = 3'd3;
        r = (i[31] ? -64'sd4096 : 64'sd0) + 2048 * i[7] + 32 * i[30:25] + 2 * i[11:8];
      end
      7'h37, 7'h17: begin fmt = 3'd4; t = i & 32'hFFFFF000; r = t; end
      7'h6F: begin
        fmt = 3'd5;
        r = (i[31] ? -64'sd1048576 : 64'sd0) + 4096 * i[19:12] + 2048 * i[20] + 2 * i[30:21];
      end
      default: begin fmt = 3'd7; r = 0; end
    endcase
    imm = (xlen == 32) ? {32'h0, r[31:0]} : r;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    logic [6:0]  ops [12];
    ops = '{7'h33, 7'h13, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom);
    return r;
  endfunction

  // One clock cycle of stimulus; the expected entry is queued when the model accepts it.
  task automatic step(input bit v, input logic [31:0] inst, input bit ordy, input bit fl);
    exp_t e;
    logic [2:0] f32;
    bit acc, pp;
    int occ_next;
    @(negedge clk);
    #1;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = {$urandom, $urandom};
    out_ready = ordy;
    flush     = fl;
    acc = v && !fl && (occ != DEPTH);
    pp  = ordy && !fl && (occ != 0);
    if (fl) begin
      exp_q.delete();
      occ_next = 0;
    end else begin
      if (acc) begin
        e.inst = inst;
        e.pc   = in_pc;
        ref_dec(inst, 32, e.imm32, f32);
        ref_dec(inst, 64, e.imm64, e.fmt);
        exp_q.push_back(e);
      end
      occ_next = occ + int'(acc) - int'(pp);
    end
    @(posedge clk);
    #1;
    occ = occ_next;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Monitor: status against model occupancy, head fields against the scoreboard on each pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      chk("count32", 64'(a_count), 64'(occ));
      chk("count64", 64'(b_count), 64'(occ));
      chk("in_ready", {62'b0, b_in_ready, a_in_ready}, {62'b0, {2{occ != DEPTH}}});
      chk("out_valid", {62'b0, b_out_valid, a_out_valid}, {62'b0, {2{occ != 0}}});
      if (!a_out_valid)
        chk("idle_zero32", 64'((|a_out_inst) | (|a_out_pc) | (|a_out_imm) | (|a_out_fmt)), 64'd0);
      if (!b_out_valid)
        chk("idle_zero64", 64'((|b_out_inst) | (|b_out_pc) | (|b_out_imm) | (|b_out_fmt)), 64'd0);
      if (a_out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("inst32", 64'(a_out_inst), 64'(e.inst));
          chk("pc32",   64'(a_out_pc),   {32'h0, e.pc[31:0]});
          chk("imm32",  64'(a_out_imm),  e.imm32);
          chk("fmt32",  64'(a_out_fmt),  64'(e.fmt));
          chk("inst64", 64'(b_out_inst), 64'(e.inst));
          chk("pc64",   b_out_pc,        e.pc);
          chk("imm64",  b_out_imm,       e.imm64);
          chk("fmt64",  64'(b_out_fmt),  64'(e.fmt));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] t_inst  [7] = '{32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h4030D093,
                               32'h0000007F, 32'h03F09093, 32'h00000033};
  logic [31:0] t_imm32 [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000003,
                               32'h0, 32'd31, 32'h0};
  logic [63:0] t_imm64 [7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h12345000,
                               64'h3, 64'h0, 64'd63, 64'h0};
  logic [2:0]  t_fmt   [7] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd7, 3'd6, 3'd0};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; occ = 0;
    #12;
    chk("reset_count", 64'(a_count), 64'd0);
    chk("reset_out_valid", 64'(a_out_valid), 64'd0);
    chk("reset_in_ready", 64'(a_in_ready), 64'd1);
    @(posedge clk); #1; rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      step(1'b1, t_inst[k], 1'b0, 1'b0);
      chk("dir_valid", 64'(a_out_valid), 64'd1);
      chk("dir_imm32", 64'(a_out_imm), 64'(t_imm32[k]));
      chk("dir_imm64", b_out_imm, t_imm64[k]);
      chk("dir_fmt", 64'(a_out_fmt), 64'(t_fmt[k]));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end

    for (int k = 0; k < DEPTH; k++) step(1'b1, rnd_inst(), 1'b0, 1'b0);
    chk("full_count", 64'(a_count), 64'(DEPTH));
    chk("full_in_ready", 64'(a_in_ready), 64'd0);
    step(1'b1, rnd_inst(), 1'b0, 1'b0);
    chk("full_hold_count", 64'(a_count), 64'(DEPTH));
    step(1'b1, rnd_inst(), 1'b1, 1'b0);
    chk("after_pop_count", 64'(a_count), 64'(DEPTH - 1));
    chk("after_pop_in_ready", 64'(a_in_ready), 64'd1);
    repeat (DEPTH) step(1'b0, 32'h0, 1'b1, 1'b0);

    for (int k = 0; k < 10; k++) step(1'b1, rnd_inst(), k[0], 1'b0);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, rnd_inst(), 1'b0, 1'b0);
    step(1'b1, rnd_inst(), 1'b0, 1'b0);
    step(1'b1, rnd_inst(), 1'b1, 1'b0);
    chk("pushpop_count", 64'(a_count), 64'd2);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, rnd_inst(), 1'b1, 1'b0);
    chk("empty_push_valid", 64'(a_out_valid), 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    repeat (3) step(1'b1, rnd_inst(), 1'b0, 1'b0);
    step(1'b1, rnd_inst(), 1'b1, 1'b1);
    chk("flush_count", 64'(a_count), 64'd0);
    chk("flush_out_valid", 64'(b_out_valid), 64'd0);
    chk("flush_out_zero", {32'h0, a_out_inst} | b_out_imm, 64'd0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);

    repeat (2) step(1'b1, rnd_inst(), 1'b0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    occ = 0;
    #1;
    chk("midrst_count", {61'b0, a_count} | {61'b0, b_count}, 64'd0);
    chk("midrst_out_valid", {62'b0, a_out_valid, b_out_valid}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    step(1'b1, rnd_inst(), 1'b0, 1'b0);
    chk("post_rst_push", 64'(a_count), 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    repeat (400)
      step($urandom_range(0, 3) != 0, rnd_inst(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
    repeat (DEPTH + 1) step(1'b0, 32'h0, 1'b1, 1'b0);

    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
